// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared control encodings for fetch, sequencer and datapath
package cpu_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_FETCH0   = 4'd0,
    ST_FETCH1   = 4'd1,
    ST_DECODE   = 4'd2,
    ST_EXEC     = 4'd3,
    ST_WB       = 4'd4,
    ST_BRANCH   = 4'd5,
    ST_MEM_ADDR = 4'd6,
    ST_MEM_RD   = 4'd7,
    ST_MEM_WR   = 4'd8,
    ST_TRAP     = 4'd9
  } state_t;

  localparam logic [2:0] OP_DATA   = 3'b000;
  localparam logic [2:0] OP_BRANCH = 3'b001;
  localparam logic [2:0] OP_LOAD   = 3'b010;
  localparam logic [2:0] OP_STORE  = 3'b011;

  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_FAULT  = 2'b10;

  localparam logic [1:0] WSEL_ALU  = 2'b00;
  localparam logic [1:0] WSEL_MEM  = 2'b01;
  localparam logic [1:0] WSEL_LINK = 2'b10;

  // true while a data-memory request is outstanding
  function automatic logic is_mem_wait(state_t s);
    return (s == ST_MEM_RD) || (s == ST_MEM_WR);
  endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// rtl/instr_sequencer_if.sv - control bundle between sequencer, fetch stage and datapath
interface instr_sequencer_if #(
  parameter int RETIRE_W = 32
);
  logic                run;
  logic                w_ir_valid;
  logic [2:0]          op_class;
  logic                s_bit;
  logic                l_bit;
  logic                mem_ready;
  logic                write_ir;
  logic                write_pc;
  logic [1:0]          pc_s;
  logic                alu_en;
  logic                write_reg;
  logic                write_flags;
  logic [1:0]          rf_wsel;
  logic                mem_req;
  logic                mem_we;
  logic                illegal;
  logic                bus_err;
  logic [RETIRE_W-1:0] retire_cnt;
  logic [3:0]          state;

  modport master (
    input  run, w_ir_valid, op_class, s_bit, l_bit, mem_ready,
    output write_ir, write_pc, pc_s, alu_en, write_reg, write_flags, rf_wsel,
    output mem_req, mem_we, illegal, bus_err, retire_cnt, state
  );

  modport slave (
    output run, w_ir_valid, op_class, s_bit, l_bit, mem_ready,
    input  write_ir, write_pc, pc_s, alu_en, write_reg, write_flags, rf_wsel,
    input  mem_req, mem_we, illegal, bus_err, retire_cnt, state
  );
endinterface

// File: rtl/mem_timeout_ctr.sv
// rtl/mem_timeout_ctr.sv - counts consecutive data-memory wait cycles and flags the limit
module mem_timeout_ctr #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         enable,
  input  logic [W-1:0] limit,
  output logic         expired
);

  logic [W-1:0] count;

  // expired fires on the limit-th consecutive cycle spent waiting
  assign expired = enable && (count >= (limit - W'(1)));

  // wait-cycle counter, cleared whenever no request is outstanding
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - multi-cycle instruction control sequencer
module instr_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int RETIRE_W    = 32
) (
  input logic                clk,
  input logic                rst,
  instr_sequencer_if.master  bus
);

  localparam int              CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MEM_TIMEOUT);

  state_t              state_q;
  state_t              state_d;
  logic                wb_from_mem_q;
  logic                trap_bus_q;
  logic [RETIRE_W-1:0] retire_q;
  logic                wait_clr;
  logic                wait_en;
  logic                wait_expired;
  logic                retire_inc;

  logic                write_ir;
  logic                write_pc;
  logic [1:0]          pc_s;
  logic                alu_en;
  logic                write_reg;
  logic                write_flags;
  logic [1:0]          rf_wsel;
  logic                mem_req;
  logic                mem_we;
  logic                illegal;
  logic                bus_err;

  assign wait_clr = !is_mem_wait(state_q);
  assign wait_en  = is_mem_wait(state_q) && !bus.mem_ready;

  mem_timeout_ctr #(
    .W(CNT_W)
  ) u_wait (
    .clk     (clk),
    .rst     (rst),
    .clear   (wait_clr),
    .enable  (wait_en),
    .limit   (LIMIT),
    .expired (wait_expired)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_FETCH0;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state decode; a late mem_ready on the limit cycle still completes normally
  always_comb begin
    state_d = ST_FETCH0;
    case (state_q)
      ST_FETCH0:   state_d = bus.run ? ST_FETCH1 : ST_FETCH0;
      ST_FETCH1:   state_d = bus.w_ir_valid ? ST_DECODE : ST_FETCH0;
      ST_DECODE: begin
        case (bus.op_class)
          OP_DATA:           state_d = ST_EXEC;
          OP_BRANCH:         state_d = ST_BRANCH;
          OP_LOAD, OP_STORE: state_d = ST_MEM_ADDR;
          default:           state_d = ST_TRAP;
        endcase
      end
      ST_EXEC:     state_d = ST_WB;
      ST_MEM_ADDR: state_d = (bus.op_class == OP_STORE) ? ST_MEM_WR : ST_MEM_RD;
      ST_MEM_RD: begin
        if (bus.mem_ready)      state_d = ST_WB;
        else if (wait_expired)  state_d = ST_TRAP;
        else                    state_d = ST_MEM_RD;
      end
      ST_MEM_WR: begin
        if (bus.mem_ready)      state_d = ST_FETCH0;
        else if (wait_expired)  state_d = ST_TRAP;
        else                    state_d = ST_MEM_WR;
      end
      default:     state_d = ST_FETCH0;
    endcase
  end

  assign retire_inc = (state_d == ST_FETCH0) &&
                      (state_q inside {ST_WB, ST_BRANCH, ST_MEM_WR, ST_FETCH1});

  // retired count, write-back source and trap cause tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      retire_q      <= '0;
      wb_from_mem_q <= 1'b0;
      trap_bus_q    <= 1'b0;
    end else begin
      if (retire_inc) begin
        retire_q <= retire_q + RETIRE_W'(1);
      end
      if (state_q == ST_EXEC) begin
        wb_from_mem_q <= 1'b0;
      end else if (state_q == ST_MEM_RD) begin
        wb_from_mem_q <= 1'b1;
      end
      if (state_d == ST_TRAP) begin
        trap_bus_q <= is_mem_wait(state_q);
      end
    end
  end

  // Moore strobe decode from the current state
  always_comb begin
    write_ir    = 1'b0;
    write_pc    = 1'b0;
    pc_s        = PC_SEQ;
    alu_en      = 1'b0;
    write_reg   = 1'b0;
    write_flags = 1'b0;
    rf_wsel     = WSEL_ALU;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    illegal     = 1'b0;
    bus_err     = 1'b0;
    case (state_q)
      ST_FETCH1: begin
        write_ir = 1'b1;
        write_pc = 1'b1;
        pc_s     = PC_SEQ;
      end
      ST_EXEC:     alu_en = 1'b1;
      ST_WB: begin
        write_reg   = 1'b1;
        rf_wsel     = wb_from_mem_q ? WSEL_MEM : WSEL_ALU;
        write_flags = !wb_from_mem_q && bus.s_bit;
      end
      ST_BRANCH: begin
        write_pc  = 1'b1;
        pc_s      = PC_BRANCH;
        write_reg = bus.l_bit;
        rf_wsel   = WSEL_LINK;
      end
      ST_MEM_ADDR: alu_en = 1'b1;
      ST_MEM_RD:   mem_req = 1'b1;
      ST_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
      end
      ST_TRAP: begin
        write_pc = 1'b1;
        pc_s     = PC_FAULT;
        illegal  = !trap_bus_q;
        bus_err  = trap_bus_q;
      end
      default: ;
    endcase
  end

  assign bus.write_ir    = write_ir;
  assign bus.write_pc    = write_pc;
  assign bus.pc_s        = pc_s;
  assign bus.alu_en      = alu_en;
  assign bus.write_reg   = write_reg;
  assign bus.write_flags = write_flags;
  assign bus.rf_wsel     = rf_wsel;
  assign bus.mem_req     = mem_req;
  assign bus.mem_we      = mem_we;
  assign bus.illegal     = illegal;
  assign bus.bus_err     = bus_err;
  assign bus.retire_cnt  = retire_q;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - randomized self-checking bench for instr_sequencer
module tb_instr_sequencer;
  import cpu_ctrl_pkg::*;

  localparam int T  = 15;
  localparam int RW = 4;

  localparam int F0  = int'(ST_FETCH0);
  localparam int F1  = int'(ST_FETCH1);
  localparam int DEC = int'(ST_DECODE);
  localparam int EXE = int'(ST_EXEC);
  localparam int WB  = int'(ST_WB);
  localparam int BR  = int'(ST_BRANCH);
  localparam int MA  = int'(ST_MEM_ADDR);
  localparam int MR  = int'(ST_MEM_RD);
  localparam int MW  = int'(ST_MEM_WR);
  localparam int TR  = int'(ST_TRAP);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_sequencer_if #(.RETIRE_W(RW)) bus ();

  instr_sequencer #(
    .MEM_TIMEOUT (T),
    .RETIRE_W    (RW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int          st;
    logic [12:0] outs;
    int          run;
    int          valid;
    int          rdy;
    logic [2:0]  op;
    bit          s;
    bit          l;
    int          ret;
  } cyc_t;

  cyc_t       plan[$];
  int         exp_ret;
  int         checks;
  int         errors;
  logic [2:0] cur_op;
  bit         cur_s;
  bit         cur_l;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [12:0] o(bit wir, bit wpc, logic [1:0] pcs, bit alu, bit wreg,
                                    bit wfl, logic [1:0] wsel, bit req, bit we, bit ill, bit berr);
    return {wir, wpc, pcs, alu, wreg, wfl, wsel, req, we, ill, berr};
  endfunction

  function automatic logic [12:0] dut_outs();
    return {bus.write_ir, bus.write_pc, bus.pc_s, bus.alu_en, bus.write_reg, bus.write_flags,
            bus.rf_wsel, bus.mem_req, bus.mem_we, bus.illegal, bus.bus_err};
  endfunction

  task automatic push(input int st, input logic [12:0] outs, input int run_v,
                      input int valid_v, input int rdy_v);
    cyc_t c;
    c.st = st; c.outs = outs; c.run = run_v; c.valid = valid_v; c.rdy = rdy_v;
    c.op = cur_op; c.s = cur_s; c.l = cur_l; c.ret = exp_ret;
    plan.push_back(c);
  endtask

  task automatic retire_one();
    exp_ret = (exp_ret + 1) % (1 << RW);
  endtask

  task automatic plan_idle(input int n);
    for (int i = 0; i < n; i++) push(F0, '0, 0, -1, -1);
  endtask

  // expected cycle trace of one instruction; k = memory cycle that sees mem_ready (k > T: never)
  task automatic plan_instr(input bit valid, input logic [2:0] op, input bit s, input bit l, input int k);
    int n;
    bit is_st;
    cur_op = op; cur_s = s; cur_l = l;
    push(F0, '0, 1, -1, -1);
    push(F1, o(1, 1, 2'b00, 0, 0, 0, 2'b00, 0, 0, 0, 0), -1, valid, -1);
    if (!valid) begin
      retire_one();
      return;
    end
    push(DEC, '0, -1, -1, -1);
    if (op == 3'b000) begin
      push(EXE, o(0, 0, 2'b00, 1, 0, 0, 2'b00, 0, 0, 0, 0), -1, -1, -1);
      push(WB,  o(0, 0, 2'b00, 0, 1, s, 2'b00, 0, 0, 0, 0), -1, -1, -1);
      retire_one();
    end else if (op == 3'b001) begin
      push(BR, o(0, 1, 2'b01, 0, l, 0, 2'b10, 0, 0, 0, 0), -1, -1, -1);
      retire_one();
    end else if (op == 3'b010 || op == 3'b011) begin
      is_st = (op == 3'b011);
      push(MA, o(0, 0, 2'b00, 1, 0, 0, 2'b00, 0, 0, 0, 0), -1, -1, -1);
      n = (k <= T) ? k : T;
      for (int i = 1; i <= n; i++)
        push(is_st ? MW : MR, o(0, 0, 2'b00, 0, 0, 0, 2'b00, 1, is_st, 0, 0), -1, -1, (i == k) ? 1 : 0);
      if (k > T) begin
        push(TR, o(0, 1, 2'b10, 0, 0, 0, 2'b00, 0, 0, 0, 1), -1, -1, -1);
      end else begin
        if (!is_st) push(WB, o(0, 0, 2'b00, 0, 1, 0, 2'b01, 0, 0, 0, 0), -1, -1, -1);
        retire_one();
      end
    end else begin
      push(TR, o(0, 1, 2'b10, 0, 0, 0, 2'b00, 0, 0, 1, 0), -1, -1, -1);
    end
  endtask

  task automatic run_cycle(input cyc_t c);
    @(negedge clk);
    bus.run        = (c.run   < 0) ? 1'($urandom_range(0, 1)) : (c.run   != 0);
    bus.w_ir_valid = (c.valid < 0) ? 1'($urandom_range(0, 1)) : (c.valid != 0);
    bus.mem_ready  = (c.rdy   < 0) ? 1'($urandom_range(0, 1)) : (c.rdy   != 0);
    bus.op_class   = c.op;
    bus.s_bit      = c.s;
    bus.l_bit      = c.l;
    #1;
    check("state", 32'(bus.state), 32'(c.st));
    check("strobes", 32'(dut_outs()), 32'(c.outs));
    check("retire_cnt", 32'(bus.retire_cnt), 32'(c.ret));
  endtask

  task automatic run_plan();
    cyc_t c;
    while (plan.size() > 0) begin
      c = plan.pop_front();
      run_cycle(c);
    end
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    bus.w_ir_valid = 1'($urandom_range(0, 1));
    bus.mem_ready  = 1'($urandom_range(0, 1));
    #1;
    check({tag, "_state"}, 32'(bus.state), 32'(F0));
    check({tag, "_strobes"}, 32'(dut_outs()), 32'd0);
    check({tag, "_retire"}, 32'(bus.retire_cnt), 32'd0);
  endtask

  initial begin
    int r;
    logic [2:0] op;
    checks = 0; errors = 0; exp_ret = 0;
    cur_op = 3'b000; cur_s = 1'b0; cur_l = 1'b0;
    bus.run = 1'b0; bus.w_ir_valid = 1'b0; bus.op_class = 3'b000;
    bus.s_bit = 1'b0; bus.l_bit = 1'b0; bus.mem_ready = 1'b0;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    repeat (2) check_idle("reset");
    rst = 1'b0;

    plan_instr(1, 3'b000, 1, 0, 0);
    plan_instr(0, 3'b000, 0, 0, 0);
    plan_instr(1, 3'b010, 0, 0, 3);
    plan_instr(1, 3'b011, 0, 0, T + 1);
    plan_instr(1, 3'b111, 0, 0, 0);
    plan_instr(1, 3'b001, 0, 1, 0);
    plan_instr(1, 3'b001, 1, 0, 0);
    plan_instr(1, 3'b011, 0, 0, T);
    plan_instr(1, 3'b010, 1, 0, T);
    plan_instr(1, 3'b010, 0, 0, T + 1);
    plan_instr(1, 3'b000, 0, 1, 0);
    plan_instr(1, 3'b100, 0, 0, 0);
    plan_idle(3);
    run_plan();

    for (int i = 0; i < 80; i++) begin
      plan_idle($urandom_range(0, 2));
      r = $urandom_range(0, 9);
      if (r <= 2)      op = 3'b000;
      else if (r <= 4) op = 3'b001;
      else if (r <= 6) op = 3'b010;
      else if (r <= 8) op = 3'b011;
      else             op = 3'(4 + $urandom_range(0, 3));
      plan_instr($urandom_range(0, 5) != 0, op, 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), $urandom_range(1, T + 2));
      run_plan();
    end
    plan_idle(1);
    run_plan();

    plan_instr(1, 3'b011, 0, 0, T + 1);
    for (int i = 0; i < 6; i++) run_cycle(plan.pop_front());
    rst = 1'b1;
    bus.run = 1'b0;
    plan.delete();
    repeat (2) check_idle("rst_mid_wait");
    rst = 1'b0;
    repeat (4) check_idle("run_low");

    exp_ret = 0;
    plan_instr(1, 3'b000, 1, 0, 0);
    plan_idle(1);
    run_plan();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have parameter MEM_TIMEOUT, default 15, max cycles a data-memory request waits for mem_ready before faulting.
REQ-002 SHALL have parameter RETIRE_W, default 32, width of the retired-instruction counter.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  reset; synchronous, active-high.
REQ-005 run  in  1  when 0, sequencer holds in FETCH0 and does not start a new fetch.
REQ-006 w_ir_valid  in  1  condition-pass flag from fetch stage for the instruction at ROM output.
REQ-007 op_class  in  3  decoded class of latched IR: 000 data-proc, 001 branch, 010 load, 011 store, others illegal.
REQ-008 s_bit, l_bit  in  1 each  set-flags bit (data-proc), link bit (branch).
REQ-009 mem_ready  in  1  data-memory completion strobe.
REQ-010 write_ir, write_pc  out  1 each  strobes to fetch stage.
REQ-011 pc_s  out  2  PC source: 00 PC+4, 01 branch target, 10 fault vector.
REQ-012 alu_en, write_reg, write_flags  out  1 each  datapath strobes.
REQ-013 rf_wsel  out  2  register write source: 00 ALU, 01 memory, 10 link.
REQ-014 mem_req, mem_we  out  1 each  data-memory request and write enable.
REQ-015 illegal, bus_err  out  1 each  one-cycle fault pulses.
REQ-016 retire_cnt  out  RETIRE_W  count of completed instructions.
REQ-017 state  out  4  current state code, for debug.

Function
REQ-018 SHALL implement states FETCH0, FETCH1, DECODE, EXEC, WB, BRANCH, MEM_ADDR, MEM_RD, MEM_WR, TRAP; all outputs except retire_cnt are Moore (decoded from state only).
REQ-019 FETCH0: all strobes 0 (ROM read latency cycle); -> FETCH1 if run, else stay.
REQ-020 FETCH1: write_ir=1, write_pc=1, pc_s=00; -> DECODE if w_ir_valid, else FETCH0 (skipped instruction, counted as retired).
REQ-021 DECODE: no strobes; op_class 000 -> EXEC, 001 -> BRANCH, 010/011 -> MEM_ADDR, other -> TRAP with illegal.
REQ-022 EXEC: alu_en=1; -> WB.
REQ-023 WB: write_reg=1; rf_wsel=00 if entered from EXEC, 01 if from MEM_RD; write_flags=s_bit only when from EXEC; -> FETCH0.
REQ-024 BRANCH: write_pc=1, pc_s=01; write_reg=l_bit, rf_wsel=10; -> FETCH0.
REQ-025 MEM_ADDR: alu_en=1; -> MEM_RD for load, MEM_WR for store (op_class held stable by latched IR).
REQ-026 MEM_RD/MEM_WR: mem_req=1, mem_we=1 only in MEM_WR, held every cycle until mem_ready sampled 1; then MEM_RD -> WB, MEM_WR -> FETCH0.
REQ-027 Wait counter SHALL clear on entry to MEM_RD/MEM_WR, increment each cycle without mem_ready; when it reaches MEM_TIMEOUT with mem_ready=0 -> TRAP with bus_err; mem_ready on the same cycle as the limit wins (normal completion).
REQ-028 TRAP: write_pc=1, pc_s=10; illegal or bus_err =1 per entry cause, for exactly this one cycle; -> FETCH0.
REQ-029 retire_cnt SHALL increment by 1 on each transition into FETCH0 from WB, BRANCH, MEM_WR, or FETCH1 (condition-fail); not from TRAP; wraps modulo 2^RETIRE_W.
REQ-030 run=0 SHALL not interrupt an instruction in progress; it takes effect only in FETCH0.
REQ-031 Unused state codes SHALL return to FETCH0 next cycle with all strobes 0.

Reset
REQ-032 rst=1 at a clock edge SHALL force state FETCH0, wait counter 0, retire_cnt 0, all strobes and fault pulses 0, regardless of current state, including mid-memory-wait.
REQ-033 Outputs SHALL reach reset values in the cycle following the rst edge and remain so while rst=1.

Structure
REQ-034 State codes, op_class codes, pc_s and rf_wsel encodings SHALL live in shared package cpu_ctrl_pkg, also used by fetch and datapath blocks.
REQ-035 Memory wait/timeout counter SHALL be sub-module mem_timeout_ctr (clear, enable, limit, expired).

Verification
REQ-036 Data-proc, s_bit=1, run=1 -> states FETCH0,FETCH1,DECODE,EXEC,WB,FETCH0 (5 cycles); write_flags=1 in WB only; retire_cnt 0->1.
REQ-037 w_ir_valid=0 in FETCH1 -> write_ir=1, write_pc=1 pc_s=00, back to FETCH0 after 2 cycles, no DECODE; retire_cnt +1.
REQ-038 Load, mem_ready asserted on 3rd MEM_RD cycle -> mem_req=1 for 3 cycles, then WB with rf_wsel=01, write_reg=1.
REQ-039 Store, mem_ready never asserted, MEM_TIMEOUT=15 -> mem_req/mem_we high 15 cycles, TRAP with bus_err=1 one cycle, pc_s=10, retire_cnt unchanged.
REQ-040 op_class=111 -> DECODE then TRAP with illegal=1, write_pc=1 pc_s=10; branch with l_bit=1 -> BRANCH pc_s=01, write_reg=1, rf_wsel=10.
REQ-041 rst=1 asserted during 2nd MEM_WR cycle -> next cycle FETCH0, mem_req=0, retire_cnt=0; run=0 afterwards keeps FETCH0 with all strobes 0.
